// File: rtl/axi4_lite_pkg.sv
// Shared constants for the AXI4-Lite register file.
//   RESP_OKAY   - normal completion
//   RESP_SLVERR - access to an out-of-range or read-only register
package axi4_lite_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle between interconnect (master) and register file (slave).
//   AW: awaddr, awaddr_valid, awready
//   W : wdata, wstrb, wdata_valid, wready
//   B : bresp, bvalid, bready
//   AR: araddr, araddr_valid, arready
//   R : rdata, rresp, rvalid, rready
interface axi4_lite_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awaddr_valid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wdata_valid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    araddr_valid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awaddr_valid, input awready,
    output wdata, wstrb, wdata_valid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, araddr_valid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awaddr_valid, output awready,
    input  wdata, wstrb, wdata_valid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, araddr_valid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_chan_buf.sv
// One-entry valid/ready holding register for an AXI request channel.
//   clk, reset   - clock, synchronous active-low reset
//   in_valid     - upstream valid
//   in_data      - upstream payload (WIDTH bits)
//   ready        - registered ready (= entry empty); low during reset
//   consume      - downstream takes the entry this cycle (only meaningful when full)
//   full, data   - held entry
module axi4_lite_chan_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             ready,
  input  logic             consume,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic accept;
  logic full_nxt;

  assign accept = in_valid && ready;

  // ready only rises when empty, so accept and consume never overlap
  always_comb begin
    full_nxt = full;
    if (consume)     full_nxt = 1'b0;
    else if (accept) full_nxt = 1'b1;
  end

  // ready is registered from full_nxt so it is held low through reset and
  // first rises the cycle after reset releases
  always_ff @(posedge clk) begin
    if (!reset) begin
      full  <= 1'b0;
      ready <= 1'b0;
      data  <= '0;
    end else begin
      full  <= full_nxt;
      ready <= !full_nxt;
      if (accept) data <= in_data;
    end
  end
endmodule

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite slave register file.
//   clk, reset - clock, synchronous active-low reset
//   bus        - AXI4-Lite slave port (AW/W/B/AR/R)
//   ro_in      - status words for read-only registers (slice n = reg n)
//   reg_out    - current read/write register contents (read-only slices read 0)
// AW and W are buffered independently; a write commits once both are held
// and the B slot is free or being drained. Reads have one-cycle latency.
module axi4_lite_regfile #(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  axi4_lite_regfile_if.slave             bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
  import axi4_lite_pkg::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] ro_arr;

  assign ro_arr  = ro_in;
  assign reg_out = regs;

  // ---------------- write channels ----------------
  logic                         aw_full, w_full, commit;
  logic [ADDR_WIDTH-1:0]        aw_addr;
  logic [DATA_WIDTH+STRB_W-1:0] w_buf;
  logic [DATA_WIDTH-1:0]        w_data;
  logic [STRB_W-1:0]            w_strb;

  assign w_data = w_buf[DATA_WIDTH-1:0];
  assign w_strb = w_buf[DATA_WIDTH+STRB_W-1:DATA_WIDTH];

  axi4_lite_chan_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.awaddr_valid),
    .in_data  (bus.awaddr),
    .ready    (bus.awready),
    .consume  (commit),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axi4_lite_chan_buf #(.WIDTH(DATA_WIDTH+STRB_W)) u_w_buf (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.wdata_valid),
    .in_data  ({bus.wstrb, bus.wdata}),
    .ready    (bus.wready),
    .consume  (commit),
    .full     (w_full),
    .data     (w_buf)
  );

  logic             aw_in_range, wr_ok;
  logic [IDX_W-1:0] aw_idx;

  // full word index is range-checked; the narrow index is only used once in range
  assign aw_in_range = 32'(aw_addr[ADDR_WIDTH-1:2]) < 32'(NUM_REGS);
  assign aw_idx      = aw_addr[IDX_W+1:2];
  assign wr_ok       = aw_in_range && !RO_MASK[aw_idx];
  // B slot is free if empty or being handed off this cycle
  assign commit      = aw_full && w_full && (!bus.bvalid || bus.bready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < STRB_W; b++)
        if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.bvalid <= 1'b0;
      bus.bresp  <= RESP_OKAY;
    end else if (commit) begin
      bus.bvalid <= 1'b1;
      bus.bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bus.bready) begin
      bus.bvalid <= 1'b0;
    end
  end

  // ---------------- read channel ----------------
  logic                  live, ar_hs, ar_in_range;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  resp_t                 rresp_nxt;

  // keeps arready low during reset, matching awready/wready
  always_ff @(posedge clk) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign bus.arready = live && (!bus.rvalid || bus.rready);
  assign ar_hs       = bus.araddr_valid && bus.arready;
  assign ar_in_range = 32'(bus.araddr[ADDR_WIDTH-1:2]) < 32'(NUM_REGS);
  assign ar_idx      = bus.araddr[IDX_W+1:2];

  always_comb begin
    rdata_nxt = '0;
    rresp_nxt = RESP_SLVERR;
    if (ar_in_range) begin
      rresp_nxt = RESP_OKAY;
      rdata_nxt = RO_MASK[ar_idx] ? ro_arr[ar_idx] : regs[ar_idx];
    end
  end

  // regs is sampled pre-commit, so a same-cycle read sees the old value
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      bus.rvalid <= 1'b1;
      bus.rdata  <= rdata_nxt;
      bus.rresp  <= rresp_nxt;
    end else if (bus.rready) begin
      bus.rvalid <= 1'b0;
    end
  end

  // byte-offset bits carry no meaning for word registers
  logic unused_lsbs;
  assign unused_lsbs = ^{aw_addr[1:0], bus.araddr[1:0]};
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile: directed vector table, hand
// sequences for ordering/backpressure/reset, and random traffic scored
// against a word-array model of the register file.
module tb_axi4_lite_regfile;
  import axi4_lite_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0204;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  logic [NR*DW-1:0] ro_in;
  logic [NR*DW-1:0] reg_out;

  axi4_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ro_in(ro_in), .reg_out(reg_out)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [NR];
  logic [31:0] ro_vals [NR];

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_wresp(input logic [7:0] a);
    int idx = int'(a[7:2]);
    if (idx >= NR) return RESP_SLVERR;
    if (RO[idx]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[7:2]);
    if (m_wresp(a) == RESP_OKAY)
      for (int b = 0; b < 4; b++)
        if (s[b]) mregs[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a[7:2]);
    if (idx >= NR) begin d = 32'h0; r = RESP_SLVERR; end
    else if (RO[idx]) begin d = ro_vals[idx]; r = RESP_OKAY; end
    else begin d = mregs[idx]; r = RESP_OKAY; end
  endtask

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = RO[i] ? 32'h0 : mregs[i];
    return f;
  endfunction

  task automatic drive_ro();
    for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = ro_vals[i];
  endtask

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_hs, w_hs;
    bit aw_done = 0, w_done = 0;
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awaddr_valid = 1'b1; bus.wdata_valid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.awaddr_valid && bus.awready;
      w_hs  = bus.wdata_valid && bus.wready;
      tick(); n++;
      if (aw_hs) begin bus.awaddr_valid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.wdata_valid = 1'b0;  w_done = 1; end
    end
    bus.awaddr_valid = 1'b0; bus.wdata_valid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    chk("b_latency", 32'(n), 32'd1);
    resp = bus.bresp;
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, resp});
    end
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs = 0;
    int n = 0;
    bus.araddr = a; bus.araddr_valid = 1'b1; bus.rready = 1'b0;
    while (!hs && n < 20) begin hs = bus.arready; tick(); n++; end
    bus.araddr_valid = 1'b0;
    chk("r_latency", bus.rvalid, 1'b1);
    d = bus.rdata; resp = bus.rresp;
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("r_hold", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, resp, d});
    end
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] rd, erd;

    vecs[0]  = '{1'b1, 8'h00, 32'h11223344, 4'b0101, RESP_OKAY,   32'h0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,        4'h0,    RESP_OKAY,   32'h00220044};
    vecs[2]  = '{1'b1, 8'h40, 32'hAAAA5555, 4'hF,    RESP_SLVERR, 32'h0};
    vecs[3]  = '{1'b0, 8'h40, 32'h0,        4'h0,    RESP_SLVERR, 32'h0};
    vecs[4]  = '{1'b1, 8'h08, 32'h12345678, 4'hF,    RESP_SLVERR, 32'h0};
    vecs[5]  = '{1'b0, 8'h08, 32'h0,        4'h0,    RESP_OKAY,   32'hCAFE0001};
    vecs[6]  = '{1'b1, 8'h07, 32'h0BADF00D, 4'h0,    RESP_OKAY,   32'h0};
    vecs[7]  = '{1'b0, 8'h05, 32'h0,        4'h0,    RESP_OKAY,   32'hDEADBEEF};
    vecs[8]  = '{1'b1, 8'h3C, 32'hFFFFFFFF, 4'b1000, RESP_OKAY,   32'h0};
    vecs[9]  = '{1'b0, 8'h3F, 32'h0,        4'h0,    RESP_OKAY,   32'hFF000000};
    vecs[10] = '{1'b0, 8'hFC, 32'h0,        4'h0,    RESP_SLVERR, 32'h0};

    bus.awaddr = '0; bus.awaddr_valid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wdata_valid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.araddr_valid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < NR; i++) begin mregs[i] = 32'h0; ro_vals[i] = $urandom; end
    ro_vals[2] = 32'hCAFE0001;
    drive_ro();

    // reset state
    repeat (3) tick();
    chk("rst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
    chk("rst_reg_out", reg_out, '0);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("idle_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    chk("idle_reg_out", reg_out, '0);

    // W first, AW three cycles later
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wdata_valid = 1'b1;
    tick();
    bus.wdata_valid = 1'b0;
    chk("w_only_readies", {bus.awready, bus.wready}, 2'b10);
    tick(); tick();
    chk("w_only_no_b", bus.bvalid, 1'b0);
    bus.awaddr = 8'h04; bus.awaddr_valid = 1'b1;
    tick();
    bus.awaddr_valid = 1'b0;
    chk("aw_hs_no_b_yet", bus.bvalid, 1'b0);
    tick();
    chk("w_first_b", {bus.bvalid, bus.bresp}, {1'b1, RESP_OKAY});
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    chk("w_first_b_drained", bus.bvalid, 1'b0);
    m_write(8'h04, 32'hDEADBEEF, 4'hF);
    axi_read(8'h04, rd, resp);
    chk("w_first_read", {resp, rd}, {RESP_OKAY, 32'hDEADBEEF});

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
    end
    chk("vec_reg_out", reg_out, m_flat());

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h47));
      if (i % 16 == 0) begin
        for (int k = 0; k < NR; k++) ro_vals[k] = $urandom;
        drive_ro();
      end
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] d;
        logic [3:0]  s;
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, resp);
        chk("rand_bresp", resp, m_wresp(a));
        m_write(a, d, s);
      end else begin
        axi_read(a, rd, resp);
        m_read(a, erd, eresp);
        chk("rand_read", {resp, rd}, {eresp, erd});
      end
    end
    chk("rand_reg_out", reg_out, m_flat());

    // read and commit to the same register in the same cycle
    axi_write(8'h14, 32'h01010101, 4'hF, resp);
    m_write(8'h14, 32'h01010101, 4'hF);
    bus.awaddr = 8'h14; bus.wdata = 32'h02020202; bus.wstrb = 4'hF;
    bus.awaddr_valid = 1'b1; bus.wdata_valid = 1'b1;
    tick();
    bus.awaddr_valid = 1'b0; bus.wdata_valid = 1'b0;
    bus.araddr = 8'h14; bus.araddr_valid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.araddr_valid = 1'b0;
    chk("rw_same_cycle_old", {bus.rvalid, bus.rdata}, {1'b1, 32'h01010101});
    chk("rw_same_cycle_b", bus.bvalid, 1'b1);
    bus.bready = 1'b1; tick(); bus.bready = 1'b0; bus.rready = 1'b0;
    m_write(8'h14, 32'h02020202, 4'hF);
    axi_read(8'h14, rd, resp);
    chk("rw_same_cycle_new", rd, 32'h02020202);

    // B backpressure with a second write queued
    bus.awaddr = 8'h0C; bus.wdata = 32'h5A5AA5A5; bus.wstrb = 4'hF;
    bus.awaddr_valid = 1'b1; bus.wdata_valid = 1'b1;
    tick();
    bus.awaddr_valid = 1'b0; bus.wdata_valid = 1'b0;
    tick();
    chk("bp_first_b", {bus.bvalid, bus.bresp}, {1'b1, RESP_OKAY});
    m_write(8'h0C, 32'h5A5AA5A5, 4'hF);
    bus.awaddr = 8'h40; bus.wdata = 32'h77777777;
    bus.awaddr_valid = 1'b1; bus.wdata_valid = 1'b1;
    tick();
    bus.awaddr_valid = 1'b0; bus.wdata_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), {bus.bvalid, bus.bresp, bus.awready, bus.wready},
          {1'b1, RESP_OKAY, 2'b00});
      tick();
    end
    bus.bready = 1'b1;
    tick();
    chk("bp_second_b", {bus.bvalid, bus.bresp}, {1'b1, RESP_SLVERR});
    tick();
    bus.bready = 1'b0;
    chk("bp_drained", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
    chk("bp_reg_out", reg_out, m_flat());

    // reset while a response is pending and a write is buffered
    bus.awaddr = 8'h10; bus.wdata = 32'h13572468;
    bus.awaddr_valid = 1'b1; bus.wdata_valid = 1'b1;
    tick();
    bus.awaddr = 8'h18; bus.wdata = 32'h9ABCDEF0;
    tick();
    tick();
    bus.awaddr_valid = 1'b0; bus.wdata_valid = 1'b0;
    chk("mid_pending", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
    reset = 1'b0;
    tick();
    chk("mid_rst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
    chk("mid_rst_reg_out", reg_out, '0);
    for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    bus.bready = 1'b1;
    repeat (3) tick();
    bus.bready = 1'b0;
    chk("mid_rst_no_stale_b", bus.bvalid, 1'b0);
    chk("mid_rst_regs_clear", reg_out, m_flat());
    axi_read(8'h0C, rd, resp);
    chk("mid_rst_read", {resp, rd}, {RESP_OKAY, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
